// File: rtl/rs_pkg.sv
// GF(2^8) helpers for the systematic Reed-Solomon encoder: field constants,
// constant multiplication and generator-polynomial coefficients.
package rs_pkg;

   localparam int         GF_W    = 8;
   localparam logic [8:0] GF_POLY = 9'h11D;

   typedef enum logic {
      S_DATA = 1'b0,
      S_PAR  = 1'b1
   } enc_state_e;

   // Shift-and-add product of two field elements; only evaluated on constants.
   function automatic logic [7:0] gf_mul_const(input logic [7:0] a,
                                               input logic [7:0] b,
                                               input logic [8:0] poly);
      logic [7:0] acc;
      logic [7:0] x;
      acc = 8'h00;
      x   = a;
      for (int i = 0; i < GF_W; i++) begin
         if (b[i]) acc = acc ^ x;
         x = x[7] ? ((x << 1) ^ poly[7:0]) : (x << 1);
      end
      return acc;
   endfunction

   // Coefficient j of g(x) = prod_{i<npar} (x + alpha^i), alpha = 2, monic.
   function automatic logic [7:0] gen_coef(input int npar,
                                           input int j,
                                           input logic [8:0] poly);
      logic [8*33-1:0] g;
      logic [7:0]      root;
      g       = '0;
      g[7:0]  = 8'h01;
      root    = 8'h01;
      for (int i = 0; i < npar; i++) begin
         // Multiply by (x + root) in place, highest coefficient first.
         for (int k = i + 1; k >= 1; k--) begin
            g[k*8 +: 8] = g[(k-1)*8 +: 8] ^ gf_mul_const(g[k*8 +: 8], root, poly);
         end
         g[7:0] = gf_mul_const(g[7:0], root, poly);
         root   = gf_mul_const(root, 8'h02, poly);
      end
      return g[j*8 +: 8];
   endfunction

endpackage

// File: rtl/rs_gf_cmul.sv
// Combinational multiply of an 8-bit field element by a constant COEF,
// built as a fixed XOR network (no tables, no general multiplier).
module rs_gf_cmul
   import rs_pkg::*;
#(
   parameter logic [7:0] COEF = 8'h01,
   parameter logic [8:0] POLY = GF_POLY
) (
   input  logic [7:0] a,
   output logic [7:0] y
);

   // Row i holds COEF * x^i; the product XORs the rows selected by bits of a.
   function automatic logic [63:0] build_rows(input logic [7:0] c,
                                              input logic [8:0] p);
      logic [63:0] rows;
      logic [7:0]  x;
      rows = '0;
      x    = c;
      for (int i = 0; i < 8; i++) begin
         rows[i*8 +: 8] = x;
         x = x[7] ? ((x << 1) ^ p[7:0]) : (x << 1);
      end
      return rows;
   endfunction

   localparam logic [63:0] ROWS = build_rows(COEF, POLY);

   always_comb begin
      y = 8'h00;
      for (int i = 0; i < 8; i++) begin
         y = y ^ (ROWS[i*8 +: 8] & {8{a[i]}});
      end
   end

endmodule

// File: rtl/rs_enc_lfsr.sv
// Streaming systematic RS encoder: K message symbols pass through, then NPAR
// parity symbols are shifted out of the LFSR, behind one output register.
module rs_enc_lfsr
   import rs_pkg::*;
#(
   parameter int         NPAR      = 16,
   parameter int         K         = 239,
   parameter logic [8:0] PRIM_POLY = 9'h11D
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       out_parity,
   output logic       out_last,
   output logic       fsm_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; valid never depends on ready, and once out_valid is raised its
   // data holds until the transfer. adv = the output register may be reloaded.

   localparam logic [7:0] K_LAST = 8'(K - 1);
   localparam logic [7:0] P_LAST = 8'(NPAR - 1);

   enc_state_e state, state_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic [7:0] par     [NPAR];
   logic [7:0] par_nxt [NPAR];
   logic [7:0] prod    [NPAR];
   logic [7:0] fb;
   logic       adv;
   logic [7:0] od_nxt;
   logic       ov_nxt;
   logic       op_nxt;
   logic       ol_nxt;

   assign adv       = out_ready | ~out_valid;
   assign fb        = in_data ^ par[NPAR-1];
   assign fsm_state = state;

   for (genvar j = 0; j < NPAR; j++) begin : g_cmul
      rs_gf_cmul #(
         .COEF (gen_coef(NPAR, j, PRIM_POLY)),
         .POLY (PRIM_POLY)
      ) u_cmul (
         .a (fb),
         .y (prod[j])
      );
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      par_nxt   = par;
      od_nxt    = out_data;
      ov_nxt    = out_valid;
      op_nxt    = out_parity;
      ol_nxt    = out_last;
      in_ready  = 1'b0;
      case (state)
         S_DATA: begin
            in_ready = adv;
            if (adv) begin
               if (in_valid) begin
                  od_nxt     = in_data;
                  ov_nxt     = 1'b1;
                  op_nxt     = 1'b0;
                  ol_nxt     = 1'b0;
                  par_nxt[0] = prod[0];
                  for (int j = 1; j < NPAR; j++) begin
                     par_nxt[j] = par[j-1] ^ prod[j];
                  end
                  if (cnt == K_LAST) begin
                     cnt_nxt   = 8'd0;
                     state_nxt = S_PAR;
                  end else begin
                     cnt_nxt = cnt + 8'd1;
                  end
               end else begin
                  ov_nxt = 1'b0;
                  op_nxt = 1'b0;
                  ol_nxt = 1'b0;
               end
            end
         end
         S_PAR: begin
            if (adv) begin
               od_nxt     = par[NPAR-1];
               ov_nxt     = 1'b1;
               op_nxt     = 1'b1;
               ol_nxt     = (cnt == P_LAST);
               par_nxt[0] = 8'h00;
               for (int j = 1; j < NPAR; j++) begin
                  par_nxt[j] = par[j-1];
               end
               // Shifting in zeros leaves the LFSR clear after the last parity.
               if (cnt == P_LAST) begin
                  cnt_nxt   = 8'd0;
                  state_nxt = S_DATA;
               end else begin
                  cnt_nxt = cnt + 8'd1;
               end
            end
         end
         default: state_nxt = S_DATA;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_DATA;
         cnt        <= 8'd0;
         out_data   <= 8'h00;
         out_valid  <= 1'b0;
         out_parity <= 1'b0;
         out_last   <= 1'b0;
         for (int j = 0; j < NPAR; j++) begin
            par[j] <= 8'h00;
         end
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         out_data   <= od_nxt;
         out_valid  <= ov_nxt;
         out_parity <= op_nxt;
         out_last   <= ol_nxt;
         for (int j = 0; j < NPAR; j++) begin
            par[j] <= par_nxt[j];
         end
      end
   end

endmodule
